// File: rtl/rr_mux_select_gen_if.sv
// Handshake bundle between the request sources and the round-robin select generator.
// The slave side is the arbiter; the master side drives requests and done.
interface rr_mux_select_gen_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] select;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  modport master (output req, output done,
                  input  select, input grant, input valid, input timeout);
  modport slave  (input  req, input done,
                  output select, output grant, output valid, output timeout);
endinterface

// File: rtl/rr_mux_select_gen.sv
// Round-robin arbiter producing the registered 2-bit select, one-hot grant and valid
// for a downstream 4:1 mux, with a hold limit that revokes long-running grants.
module rr_mux_select_gen #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_select_gen_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       winner;
  logic             rel_done, rel_wd, rel_hold;

  // First set request strictly after the previous owner, wrapping 3->0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner   = rr_pick(bus.req, last_q);
  assign rel_done = bus.done;
  assign rel_wd   = !bus.req[sel_q];
  assign rel_hold = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (|bus.req) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (rel_done || rel_wd || rel_hold) begin
          state_d   = IDLE;
          last_d    = sel_q;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          cnt_d     = '0;
          // Only a pure hold-limit revocation is reported as a timeout.
          timeout_d = !rel_done && !rel_wd;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      last_q    <= 2'b11;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.select  = sel_q;
  assign bus.grant   = grant_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_select_gen.sv
// Directed bench for rr_mux_select_gen: HOLD_MAX=8 instance for the main sequence,
// HOLD_MAX=1 instance for the single-cycle-grant corner.
module tb_rr_mux_select_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  rr_mux_select_gen_if bus0();
  rr_mux_select_gen_if bus1();

  rr_mux_select_gen #(.HOLD_MAX(8), .CNT_W(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rr_mux_select_gen #(.HOLD_MAX(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Packed view: {select[1:0], grant[3:0], valid, timeout}
  function automatic logic [7:0] out0();
    return {bus0.select, bus0.grant, bus0.valid, bus0.timeout};
  endfunction

  function automatic logic [7:0] out1();
    return {bus1.select, bus1.grant, bus1.valid, bus1.timeout};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed sel/gnt/vld/to=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after an edge; reset is asserted and released between edges.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_state", out0(), 8'b00_0000_0_0);
    #1;
    rst_n = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    bus1.req  = 4'b0000;
    bus1.done = 1'b0;
    step();
    step();

    // 1: single requester, released by done
    bus0.req = 4'b0100;
    do_reset();
    step();
    chk("t1_grant_c1", out0(), {2'b10, 4'b0100, 1'b1, 1'b0});
    step();
    step();
    chk("t1_grant_c3", out0(), {2'b10, 4'b0100, 1'b1, 1'b0});
    bus0.done = 1'b1;
    step();
    chk("t1_release", out0(), {2'b10, 4'b0000, 1'b0, 1'b0});
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;
    step();
    chk("t1_idle_hold_sel", out0(), {2'b10, 4'b0000, 1'b0, 1'b0});

    // 2: all requesting, done on second grant cycle -> 0,1,2,3,0
    bus0.req = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_grant", out0(), {2'(order[i]), 4'b0001 << order[i], 1'b1, 1'b0});
      step();
      bus0.done = 1'b1;
      step();
      chk("t2_bubble", out0(), {2'(order[i]), 4'b0000, 1'b0, 1'b0});
      bus0.done = 1'b0;
    end

    // 3: hold limit revokes after exactly 8 cycles
    bus0.req = 4'b0001;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t3_hold", out0(), {2'b00, 4'b0001, 1'b1, 1'b0});
    end
    step();
    chk("t3_timeout", out0(), {2'b00, 4'b0000, 1'b0, 1'b1});
    step();
    chk("t3_regrant", out0(), {2'b00, 4'b0001, 1'b1, 1'b0});
    bus0.req = 4'b0000;
    step();
    chk("t3_withdraw", out0(), {2'b00, 4'b0000, 1'b0, 1'b0});

    // 5: done coincides with the hold limit -> no timeout
    bus0.req = 4'b0001;
    do_reset();
    for (int k = 1; k <= 8; k++) step();
    chk("t5_last_cycle", out0(), {2'b00, 4'b0001, 1'b1, 1'b0});
    bus0.done = 1'b1;
    step();
    chk("t5_no_timeout", out0(), {2'b00, 4'b0000, 1'b0, 1'b0});
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;

    // 4: owner 2 withdraws while 3 waits
    bus0.req = 4'b0100;
    do_reset();
    step();
    chk("t4_grant2", out0(), {2'b10, 4'b0100, 1'b1, 1'b0});
    bus0.req = 4'b1100;
    step();
    chk("t4_other_ignored", out0(), {2'b10, 4'b0100, 1'b1, 1'b0});
    bus0.req = 4'b1000;
    step();
    chk("t4_withdraw", out0(), {2'b10, 4'b0000, 1'b0, 1'b0});
    step();
    chk("t4_grant3", out0(), {2'b11, 4'b1000, 1'b1, 1'b0});

    // 6: asynchronous reset mid-grant, pointer back to 3
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", out0(), 8'b00_0000_0_0);
    bus0.req = 4'b1001;
    #1;
    rst_n = 1'b1;
    step();
    chk("t6_ptr_restored", out0(), {2'b00, 4'b0001, 1'b1, 1'b0});
    bus0.req = 4'b0000;

    // HOLD_MAX=1: one-cycle grants, timeout unless done
    bus1.req = 4'b0001;
    do_reset();
    step();
    chk("h1_grant", out1(), {2'b00, 4'b0001, 1'b1, 1'b0});
    step();
    chk("h1_timeout", out1(), {2'b00, 4'b0000, 1'b0, 1'b1});
    step();
    chk("h1_regrant", out1(), {2'b00, 4'b0001, 1'b1, 1'b0});
    bus1.done = 1'b1;
    step();
    chk("h1_done_no_timeout", out1(), {2'b00, 4'b0000, 1'b0, 1'b0});
    bus1.done = 1'b0;
    bus1.req  = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
